// File: rtl/writeback_stage_if.sv
// MEM/WB bus bundle: memory-stage results in, register-bank write port and forwarding outputs out.
// The slave modport is the write-back stage's view; the master modport is the driver side.
interface writeback_stage_if #(
   parameter int SIZE         = 32,
   parameter int SIZE_REG_DIR = 5
);
   logic                    i_stall;
   logic                    i_flush;
   logic                    i_reg_write;
   logic                    i_mem_to_reg;
   logic                    i_link;
   logic                    i_halt;
   logic [1:0]              i_load_size;
   logic                    i_load_unsigned;
   logic [1:0]              i_byte_offset;
   logic [SIZE-1:0]         i_alu_result;
   logic [SIZE-1:0]         i_mem_data;
   logic [SIZE-1:0]         i_pc_plus8;
   logic [SIZE_REG_DIR-1:0] i_rd;
   logic [SIZE_REG_DIR-1:0] o_w_dir;
   logic [SIZE-1:0]         o_w_data;
   logic                    o_write_enable;
   logic                    o_halt;

   modport master (
      output i_stall, i_flush, i_reg_write, i_mem_to_reg, i_link, i_halt,
             i_load_size, i_load_unsigned, i_byte_offset,
             i_alu_result, i_mem_data, i_pc_plus8, i_rd,
      input  o_w_dir, o_w_data, o_write_enable, o_halt
   );

   modport slave (
      input  i_stall, i_flush, i_reg_write, i_mem_to_reg, i_link, i_halt,
             i_load_size, i_load_unsigned, i_byte_offset,
             i_alu_result, i_mem_data, i_pc_plus8, i_rd,
      output o_w_dir, o_w_data, o_write_enable, o_halt
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back mux with sub-word load extraction and sticky halt.
// Optional retired-instruction counter (o_retired) is built only when WB_RETIRE_COUNT_EN is defined.
module writeback_stage #(
   parameter int SIZE          = 32,
   parameter int NUM_REGISTERS = 32,
   parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS)
) (
   input  logic                clk,
   input  logic                rst,
   writeback_stage_if.slave    wb
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [31:0]         o_retired
`endif
);

   logic                    valid_q;
   logic                    reg_write_q;
   logic [SIZE_REG_DIR-1:0] rd_q;
   logic                    halt_q;
   logic [SIZE-1:0]         result_q;
   logic                    halted_q;

   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [SIZE-1:0]         load_val;
   logic [SIZE-1:0]         result_d;
   logic                    capture;

   assign capture = ~wb.i_flush & ~wb.i_stall;

   // Little-endian lane select; halfword ignores offset bit 0, word ignores the offset entirely.
   always_comb begin
      byte_sel = wb.i_mem_data[{wb.i_byte_offset, 3'b000} +: 8];
      half_sel = wb.i_mem_data[{wb.i_byte_offset[1], 4'b0000} +: 16];
      load_val = wb.i_mem_data;
      case (wb.i_load_size)
         2'b00:   load_val = wb.i_load_unsigned ? {{(SIZE-8){1'b0}}, byte_sel}
                                                : {{(SIZE-8){byte_sel[7]}}, byte_sel};
         2'b01:   load_val = wb.i_load_unsigned ? {{(SIZE-16){1'b0}}, half_sel}
                                                : {{(SIZE-16){half_sel[15]}}, half_sel};
         default: load_val = wb.i_mem_data;
      endcase
   end

   always_comb begin
      result_d = wb.i_alu_result;
      if (wb.i_link)
         result_d = wb.i_pc_plus8;
      else if (wb.i_mem_to_reg)
         result_d = load_val;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         halt_q      <= 1'b0;
         result_q    <= '0;
         halted_q    <= 1'b0;
      end else if (wb.i_flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         halt_q      <= 1'b0;
      end else if (!wb.i_stall) begin
         valid_q     <= 1'b1;
         reg_write_q <= wb.i_reg_write;
         rd_q        <= wb.i_rd;
         halt_q      <= wb.i_halt;
         result_q    <= result_d;
         if (wb.i_halt)
            halted_q <= 1'b1;
      end
   end

   // halted_q is already set when the HALT itself sits in the stage, so it also blocks HALT's own write.
   assign wb.o_write_enable = valid_q & reg_write_q & (rd_q != '0) & ~halt_q & ~halted_q;
   assign wb.o_w_dir        = rd_q;
   assign wb.o_w_data       = result_q;
   assign wb.o_halt         = halted_q;

`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retired_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         retired_q <= '0;
      else if (capture && !halted_q)
         retired_q <= retired_q + 32'd1;
   end

   assign o_retired = retired_q;
`else
   logic unused_capture;
   assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected write-port state queued per driven edge, popped after it.
module tb_writeback_stage;

   typedef struct {
      logic        we;
      logic [4:0]  dir;
      logic [31:0] data;
      logic        halt;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb[$];
   exp_t e;
   logic [31:0] retire_model;
   logic        model_halt;

   writeback_stage_if #(.SIZE(32), .SIZE_REG_DIR(5)) wb ();

`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retired;
   writeback_stage dut (.clk(clk), .rst(rst), .wb(wb), .o_retired(retired));
`else
   writeback_stage dut (.clk(clk), .rst(rst), .wb(wb));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      wb.i_stall = 0; wb.i_flush = 0; wb.i_reg_write = 0; wb.i_mem_to_reg = 0;
      wb.i_link = 0; wb.i_halt = 0; wb.i_load_size = 2'b10; wb.i_load_unsigned = 0;
      wb.i_byte_offset = 0; wb.i_alu_result = 0; wb.i_mem_data = 0;
      wb.i_pc_plus8 = 0; wb.i_rd = 0;
   endtask

   // Advances one edge and keeps the bench's retirement/halt model in step with the inputs just driven.
   task automatic tick();
      if (!wb.i_flush && !wb.i_stall && !model_halt) retire_model = retire_model + 1;
      if (!wb.i_flush && !wb.i_stall && wb.i_halt) model_halt = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 0;
      clear_inputs();
      retire_model = 0;
      model_halt = 0;
      repeat (2) @(posedge clk);
      #1;
      e = '{we: 0, dir: 0, data: 0, halt: 0};
      checks++;
      if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt} !== {e.we, e.dir, e.data, e.halt}) begin
         failures++;
         $display("FAIL reset: got we=%b dir=%0d data=%h halt=%b want we=%b dir=%0d data=%h halt=%b",
                  wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt, e.we, e.dir, e.data, e.halt);
      end
`ifdef WB_RETIRE_COUNT_EN
      checks++;
      if (retired !== 32'd0) begin
         failures++;
         $display("FAIL reset_retired: got %h want 00000000", retired);
      end
`endif
      rst = 1;
   endtask

   task automatic test_alu_write();
      clear_inputs();
      wb.i_alu_result = 32'h0000_1234; wb.i_rd = 5; wb.i_reg_write = 1;
      sb.push_back('{we: 1, dir: 5, data: 32'h0000_1234, halt: 0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt} !== {e.we, e.dir, e.data, e.halt}) begin
         failures++;
         $display("FAIL alu_write: got we=%b dir=%0d data=%h halt=%b want we=%b dir=%0d data=%h halt=%b",
                  wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt, e.we, e.dir, e.data, e.halt);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz  [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
      logic        uns [7] = '{0, 1, 0, 0, 1, 0, 1};
      logic [1:0]  off [7] = '{3, 3, 2, 1, 1, 1, 2};
      logic [31:0] want[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F81,
                               32'h0000_7F81, 32'h0000_007F, 32'h0000_00FF};
      clear_inputs();
      wb.i_mem_data = 32'h80FF_7F81; wb.i_alu_result = 32'hDEAD_0000;
      wb.i_mem_to_reg = 1; wb.i_reg_write = 1; wb.i_rd = 10;
      for (int i = 0; i < 7; i++) begin
         wb.i_load_size = sz[i]; wb.i_load_unsigned = uns[i]; wb.i_byte_offset = off[i];
         sb.push_back('{we: 1, dir: 10, data: want[i], halt: 0});
         tick();
         e = sb.pop_front();
         checks++;
         if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data} !== {e.we, e.dir, e.data}) begin
            failures++;
            $display("FAIL load_%0d: got we=%b dir=%0d data=%h want we=%b dir=%0d data=%h",
                     i, wb.o_write_enable, wb.o_w_dir, wb.o_w_data, e.we, e.dir, e.data);
         end
      end
   endtask

   task automatic test_link_r0();
      logic [4:0] rds[2] = '{5'd31, 5'd0};
      clear_inputs();
      wb.i_link = 1; wb.i_mem_to_reg = 1; wb.i_reg_write = 1;
      wb.i_pc_plus8 = 32'h40; wb.i_alu_result = 32'h1111; wb.i_mem_data = 32'h2222;
      for (int i = 0; i < 2; i++) begin
         wb.i_rd = rds[i];
         sb.push_back('{we: (rds[i] != 0), dir: rds[i], data: 32'h40, halt: 0});
         tick();
         e = sb.pop_front();
         checks++;
         if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data} !== {e.we, e.dir, e.data}) begin
            failures++;
            $display("FAIL link_rd%0d: got we=%b dir=%0d data=%h want we=%b dir=%0d data=%h",
                     rds[i], wb.o_write_enable, wb.o_w_dir, wb.o_w_data, e.we, e.dir, e.data);
         end
      end
   endtask

   task automatic test_stall_flush();
      clear_inputs();
      wb.i_reg_write = 1; wb.i_rd = 9; wb.i_alu_result = 32'h0000_ABCD;
      sb.push_back('{we: 1, dir: 9, data: 32'h0000_ABCD, halt: 0});
      tick();
      wb.i_stall = 1; wb.i_rd = 3; wb.i_alu_result = 32'h5555_5555;
      for (int i = 0; i < 3; i++) sb.push_back('{we: 1, dir: 9, data: 32'h0000_ABCD, halt: 0});
      wb.i_flush = 1;
      sb.push_back('{we: 0, dir: 9, data: 32'h0000_ABCD, halt: 0});
      wb.i_flush = 0;
      e = sb.pop_front();
      checks++;
      if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data} !== {e.we, e.dir, e.data}) begin
         failures++;
         $display("FAIL stall_capture: got we=%b dir=%0d data=%h want we=%b dir=%0d data=%h",
                  wb.o_write_enable, wb.o_w_dir, wb.o_w_data, e.we, e.dir, e.data);
      end
      for (int i = 0; i < 4; i++) begin
         wb.i_flush = (i == 3);
         tick();
         e = sb.pop_front();
         checks++;
         if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data} !== {e.we, e.dir, e.data}) begin
            failures++;
            $display("FAIL stall_cycle%0d: got we=%b dir=%0d data=%h want we=%b dir=%0d data=%h",
                     i, wb.o_write_enable, wb.o_w_dir, wb.o_w_data, e.we, e.dir, e.data);
         end
      end
`ifdef WB_RETIRE_COUNT_EN
      checks++;
      if (retired !== retire_model) begin
         failures++;
         $display("FAIL stall_retired: got %0d want %0d", retired, retire_model);
      end
`endif
   endtask

   task automatic test_halt();
      clear_inputs();
      wb.i_halt = 1;
      sb.push_back('{we: 0, dir: 0, data: 0, halt: 1});
      tick();
      e = sb.pop_front();
      checks++;
      if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt} !== {e.we, e.dir, e.data, e.halt}) begin
         failures++;
         $display("FAIL halt_capture: got we=%b dir=%0d data=%h halt=%b want we=%b dir=%0d data=%h halt=%b",
                  wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt, e.we, e.dir, e.data, e.halt);
      end
      clear_inputs();
      wb.i_reg_write = 1; wb.i_rd = 7; wb.i_alu_result = 32'h77;
      sb.push_back('{we: 0, dir: 7, data: 32'h77, halt: 1});
      tick();
      e = sb.pop_front();
      checks++;
      if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt} !== {e.we, e.dir, e.data, e.halt}) begin
         failures++;
         $display("FAIL halt_after: got we=%b dir=%0d data=%h halt=%b want we=%b dir=%0d data=%h halt=%b",
                  wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt, e.we, e.dir, e.data, e.halt);
      end
`ifdef WB_RETIRE_COUNT_EN
      checks++;
      if (retired !== retire_model) begin
         failures++;
         $display("FAIL halt_retired: got %0d want %0d", retired, retire_model);
      end
`endif
      #2;
      rst = 0;
      #1;
      checks++;
      if ({wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL halt_async_reset: got we=%b dir=%0d data=%h halt=%b want all zero",
                  wb.o_write_enable, wb.o_w_dir, wb.o_w_data, wb.o_halt);
      end
      @(negedge clk);
      rst = 1;
      retire_model = 0;
      model_halt = 0;
      @(posedge clk);
      #1;
   endtask

`ifdef WB_RETIRE_COUNT_EN
   task automatic test_wrap();
      clear_inputs();
      wb.i_stall = 1;
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      retire_model = 32'hFFFF_FFFF;
      wb.i_stall = 0; wb.i_reg_write = 1; wb.i_rd = 4; wb.i_alu_result = 32'h4;
      tick();
      checks++;
      if (retired !== retire_model) begin
         failures++;
         $display("FAIL retire_wrap: got %h want %h", retired, retire_model);
      end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_alu_write();
      test_loads();
      test_link_r0();
      test_stall_flush();
      test_halt();
`ifdef WB_RETIRE_COUNT_EN
      test_wrap();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and write-back unit of the MIPS pipeline. It latches results leaving the memory stage, extracts and extends sub-word loads, and selects the final value: ALU result, load data or link address. It drives the register bank write port and the MEM/WB forwarding inputs of the decode stage. It also tracks the program halt and, optionally, a retired-instruction count for the debug unit.

## Interface
- SIZE, 32, datapath width
- NUM_REGISTERS, 32, register bank depth
- SIZE_REG_DIR, $clog2(NUM_REGISTERS), register address width

- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_stall  in  1  hold stage register contents
- i_flush  in  1  load a bubble instead of the incoming instruction
- i_reg_write  in  1  incoming instruction writes a register
- i_mem_to_reg  in  1  result comes from memory
- i_link  in  1  result is i_pc_plus8 (JAL/JALR)
- i_halt  in  1  incoming instruction is HALT
- i_load_size  in  2  00 byte, 01 halfword, 1x word
- i_load_unsigned  in  1  zero-extend sub-word loads
- i_byte_offset  in  2  address bits [1:0] of the load
- i_alu_result  in  SIZE  ALU result from EX/MEM
- i_mem_data  in  SIZE  raw data-memory read word
- i_pc_plus8  in  SIZE  link address
- i_rd  in  SIZE_REG_DIR  destination register
- o_w_dir  out  SIZE_REG_DIR  register bank write address; also MEM/WB forwarding rd
- o_w_data  out  SIZE  register bank write data; also MEM/WB forwarding data
- o_write_enable  out  1  register bank write strobe; also MEM/WB forwarding reg-write flag
- o_halt  out  1  sticky; HALT has retired
- o_retired  out  32  retired-instruction count (only with WB_RETIRE_COUNT_EN)

## Operation
- Stage register fields: valid, reg_write, rd, halt, result[SIZE].
- Capture priority on each edge: i_flush loads a bubble (valid=0, reg_write=0, halt=0), even with i_stall. Otherwise i_stall holds all fields. Otherwise the incoming instruction is loaded with valid=1.
- The result is computed combinationally from the inputs and registered. Select priority: i_link → i_pc_plus8; else i_mem_to_reg → extracted load; else i_alu_result.
- Load extraction is little-endian:
  - Byte: i_mem_data[8*off +: 8].
  - Halfword: i_mem_data[16*off[1] +: 16]; off[0] is ignored.
  - Word: the whole word; offset is ignored.
  - Sub-word values are sign-extended to SIZE, or zero-extended when i_load_unsigned=1.
- o_write_enable = valid & reg_write & (rd != 0) & ~halted_before. Writes to r0 are always suppressed.
- o_w_data and o_w_dir always reflect the stage register, even when o_write_enable=0.
- Halt: o_halt sets on the edge a valid HALT is captured and stays set until reset. Instructions captured after that edge are latched but never raise o_write_enable. The HALT instruction itself writes nothing.

## Timing
- Latency: 1 cycle, inputs to o_w_* outputs. The register bank writes on the following edge.
- Reset (rst=0, asynchronous): valid=0, reg_write=0, rd=0, result=0, o_halt=0, o_retired=0. All outputs read 0 during reset.
- Reset released mid-stream: the first capture occurs on the first rising edge with rst=1.
- Stall: outputs are held stable, so a held write re-asserts o_write_enable every stalled cycle. Re-writing the same value is harmless.
- Stall and flush in the same cycle: flush wins.

## Configuration
- WB_RETIRE_COUNT_EN defined:
  - o_retired exists.
  - It increments by 1 on each edge that captures a valid, non-flushed, non-stalled instruction while o_halt=0. HALT itself counts.
  - It wraps from 0xFFFFFFFF to 0.
- WB_RETIRE_COUNT_EN undefined: the o_retired port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then ALU write: i_alu_result=0x0000_1234, i_rd=5, i_reg_write=1 → next cycle o_write_enable=1, o_w_dir=5, o_w_data=0x0000_1234.
- Loads: i_mem_data=0x80FF_7F81.
  - Byte, off=3, signed → 0xFFFF_FF80.
  - Byte, off=3, unsigned → 0x0000_0080.
  - Half, off=2, signed → 0xFFFF_80FF.
  - Word → 0x80FF_7F81.
- Link and r0: i_link=1, i_pc_plus8=0x40, i_rd=31 → o_w_data=0x40, o_write_enable=1. Same with i_rd=0 → o_write_enable=0.
- Stall/flush: write captured, then i_stall=1 for 3 cycles → outputs unchanged. Then i_stall=1 with i_flush=1 → o_write_enable=0. o_retired (if enabled) counts exactly 1.
- Halt: HALT followed by a write to r7 → o_halt=1 from the HALT capture onward and o_write_enable stays 0. Assert rst=0 mid-cycle → o_halt=0 immediately.
- Counter wrap (WB_RETIRE_COUNT_EN, counter forced to 0xFFFF_FFFF) → one retired instruction gives o_retired=0.
